// File: rtl/swervolf_gpio_pkg.sv
// swervolf_gpio_pkg
//   Shared definitions for the GPIO bank: register word addresses, register
//   count, bus data width, parameter legality check and byte-lane mask helper.
package swervolf_gpio_pkg;

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_IN   = 3'd1;
  localparam logic [2:0] REG_DIR  = 3'd2;
  localparam logic [2:0] REG_IE   = 3'd3;
  localparam logic [2:0] REG_POL  = 3'd4;
  localparam logic [2:0] REG_STAT = 3'd5;

  localparam int unsigned NUM_REGS = 6;
  localparam int unsigned WB_DW    = 32;

  // Legal ranges: 1..32 channels, 2..4 synchroniser stages.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned stages);
    return (width >= 1) && (width <= 32) && (stages >= 2) && (stages <= 4);
  endfunction

  // Expand the 4 Wishbone byte selects into a 32-bit write mask.
  function automatic logic [WB_DW-1:0] byte_mask(input logic [3:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/swervolf_gpio_sync.sv
// swervolf_gpio_sync
//   Per-bit input synchroniser chain followed by a "previous value" register
//   used for edge detection.
//   Ports:
//     clk, rstn  clock / asynchronous active-low reset
//     d          asynchronous pad inputs
//     sync       output of the last synchroniser stage
//     rise/fall  sync went 0->1 / 1->0 relative to the previous cycle
module swervolf_gpio_sync
  import swervolf_gpio_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [STAGES-1:0][W-1:0] chain;
  logic [W-1:0]             prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/swervolf_gpio.sv
// swervolf_gpio
//   Wishbone-slave GPIO bank with WIDTH bidirectional channels: output
//   register, per-bit output enable, synchronised input readback and
//   edge-triggered, maskable, write-1-to-clear interrupt status.
//   Ports:
//     clk, rstn            clock / asynchronous active-low reset
//     i_wb_*               Wishbone slave inputs (adr = word address)
//     o_wb_rdt, o_wb_ack   registered read data and single-cycle ack
//     i_gpio               asynchronous pad inputs
//     o_gpio, o_gpio_oe    pad output values / output enables (1 = drive)
//     o_irq                level interrupt, |(STAT & IE)
module swervolf_gpio
  import swervolf_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       i_wb_adr,
  input  logic [31:0]      i_wb_dat,
  input  logic [3:0]       i_wb_sel,
  input  logic             i_wb_we,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  output logic [31:0]      o_wb_rdt,
  output logic             o_wb_ack,
  input  logic [WIDTH-1:0] i_gpio,
  output logic [WIDTH-1:0] o_gpio,
  output logic [WIDTH-1:0] o_gpio_oe,
  output logic             o_irq
);

  if (!params_ok(WIDTH, SYNC_STAGES)) begin : g_bad_params
    $error("swervolf_gpio: WIDTH must be 1..32 and SYNC_STAGES 2..4");
  end

  logic [WIDTH-1:0] out_q, dir_q, ie_q, pol_q, stat_q;
  logic [WIDTH-1:0] sync_v, rise_v, fall_v, ev;
  logic [WIDTH-1:0] wmask, wdat, stat_clr;
  logic [WB_DW-1:0] mask32, rd_data;
  logic             access, wr;

  swervolf_gpio_sync #(
    .W      (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (i_gpio),
    .sync (sync_v),
    .rise (rise_v),
    .fall (fall_v)
  );

  // The ack term blocks a second access while ack is high, giving one access per two cycles.
  assign access = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign wr     = access & i_wb_we;

  assign mask32 = byte_mask(i_wb_sel);
  assign wmask  = mask32[WIDTH-1:0];
  assign wdat   = i_wb_dat[WIDTH-1:0] & wmask;

  assign ev       = (pol_q & rise_v) | (~pol_q & fall_v);
  assign stat_clr = (wr && (i_wb_adr == REG_STAT)) ? wdat : '0;

  always_comb begin
    rd_data = '0;
    case (i_wb_adr)
      REG_OUT:  rd_data[WIDTH-1:0] = out_q;
      REG_IN:   rd_data[WIDTH-1:0] = sync_v;
      REG_DIR:  rd_data[WIDTH-1:0] = dir_q;
      REG_IE:   rd_data[WIDTH-1:0] = ie_q;
      REG_POL:  rd_data[WIDTH-1:0] = pol_q;
      REG_STAT: rd_data[WIDTH-1:0] = stat_q;
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= '0;
    end else begin
      o_wb_ack <= access;
      o_wb_rdt <= access ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q <= RESET_OUT;
      dir_q <= '0;
      ie_q  <= '0;
      pol_q <= '0;
    end else if (wr) begin
      case (i_wb_adr)
        REG_OUT: out_q <= (out_q & ~wmask) | wdat;
        REG_DIR: dir_q <= (dir_q & ~wmask) | wdat;
        REG_IE:  ie_q  <= (ie_q  & ~wmask) | wdat;
        REG_POL: pol_q <= (pol_q & ~wmask) | wdat;
        default: ;
      endcase
    end
  end

  // Set is applied after clear so a same-cycle event keeps the bit set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_q <= '0;
    end else begin
      stat_q <= (stat_q & ~stat_clr) | (ev & ie_q);
    end
  end

  assign o_gpio    = out_q;
  assign o_gpio_oe = dir_q;
  assign o_irq     = |(stat_q & ie_q);

endmodule

// File: tb/tb_swervolf_gpio.sv
module tb_swervolf_gpio;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;
  localparam logic [W-1:0] ROUT = 16'h00A5;

  logic          clk;
  logic          rstn;
  logic [2:0]    adr;
  logic [31:0]   dat;
  logic [3:0]    sel;
  logic          we, cyc, stb;
  logic [31:0]   rdt;
  logic          ack;
  logic [W-1:0]  gin, gout, goe;
  logic          irq;

  int vectors = 0;
  int miscompares = 0;

  swervolf_gpio #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .RESET_OUT   (ROUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .i_wb_adr  (adr),
    .i_wb_dat  (dat),
    .i_wb_sel  (sel),
    .i_wb_we   (we),
    .i_wb_cyc  (cyc),
    .i_wb_stb  (stb),
    .o_wb_rdt  (rdt),
    .o_wb_ack  (ack),
    .i_gpio    (gin),
    .o_gpio    (gout),
    .o_gpio_oe (goe),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register file plus pad inputs delayed by the
  // synchroniser depth; edges derived from consecutive delayed samples.
  logic [W-1:0]  m_out, m_dir, m_ie, m_pol, m_stat;
  logic          m_ack;
  logic [W-1:0]  phist[$];
  logic [31:0]   expq[$];

  function automatic logic [31:0] mread(input logic [2:0] a, input logic [W-1:0] in_v);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0: r[W-1:0] = m_out;
      3'd1: r[W-1:0] = in_v;
      3'd2: r[W-1:0] = m_dir;
      3'd3: r[W-1:0] = m_ie;
      3'd4: r[W-1:0] = m_pol;
      3'd5: r[W-1:0] = m_stat;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] merge(input logic [W-1:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < W; i++) if (s[i/8]) r[i] = d[i];
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_out = ROUT; m_dir = '0; m_ie = '0; m_pol = '0; m_stat = '0; m_ack = 1'b0;
      phist.delete();
      for (int i = 0; i <= S; i++) phist.push_back('0);
      expq.delete();
    end else begin
      logic [W-1:0] s_now, s_prev, setv, clrv;
      logic acc;
      s_now  = phist[S-1];
      s_prev = phist[S];
      setv = '0;
      for (int i = 0; i < W; i++) begin
        if (m_ie[i] && (m_pol[i] ? (s_now[i] && !s_prev[i]) : (!s_now[i] && s_prev[i])))
          setv[i] = 1'b1;
      end
      acc  = cyc && stb && !m_ack;
      clrv = '0;
      if (acc) begin
        expq.push_back(mread(adr, s_now));
        if (we) begin
          case (adr)
            3'd0: m_out = merge(m_out, dat, sel);
            3'd2: m_dir = merge(m_dir, dat, sel);
            3'd4: m_pol = merge(m_pol, dat, sel);
            3'd5: clrv  = merge('0, dat, sel);
            default: ;
          endcase
        end
      end
      m_stat = (m_stat & ~clrv) | setv;
      if (acc && we && adr == 3'd3) m_ie = merge(m_ie, dat, sel);
      m_ack = acc;
      phist.push_front(gin);
      void'(phist.pop_back());
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    vectors++;
    if (gout !== m_out || goe !== m_dir || irq !== (|(m_stat & m_ie)) || ack !== m_ack) begin
      miscompares++;
      $display("FAIL pins @%0t: gpio=%h oe=%h irq=%b ack=%b, expected gpio=%h oe=%h irq=%b ack=%b",
               $time, gout, goe, irq, ack, m_out, m_dir, |(m_stat & m_ie), m_ack);
    end
    if (ack === 1'b1) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL rdt @%0t: unexpected ack, rdt=%h", $time, rdt);
      end else begin
        e = expq.pop_front();
        if (rdt !== e) begin
          miscompares++;
          $display("FAIL rdt @%0t: got %h expected %h", $time, rdt, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a falling edge; returns after ack has come and gone.
  task automatic bus(input logic [2:0] a, input logic w, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] r);
    adr = a; we = w; sel = s; dat = d; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    r = rdt;
    chk("ack", {31'd0, ack}, 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(a, 1'b1, 4'hF, d, r);
  endtask

  task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] r;
    bus(a, 1'b0, 4'hF, 32'd0, r);
    chk(nm, r, exp);
  endtask

  initial begin
    logic [31:0] r;
    rstn = 1'b0;
    cyc = 0; stb = 0; we = 0; adr = '0; dat = '0; sel = '0; gin = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Reset values
    rd("reset OUT", 3'd0, 32'h0000_00A5);
    rd("reset DIR", 3'd2, 32'd0);
    rd("reset IE", 3'd3, 32'd0);
    rd("reset POL", 3'd4, 32'd0);
    rd("reset STAT", 3'd5, 32'd0);
    chk("reset irq", {31'd0, irq}, 32'd0);

    // Byte lanes and out-of-width bits
    bus(3'd0, 1'b1, 4'b0011, 32'hDEAD_BEEF, r);
    chk("sel 0011", {16'd0, gout}, 32'h0000_BEEF);
    bus(3'd0, 1'b1, 4'b1100, 32'h1234_5678, r);
    chk("sel 1100", {16'd0, gout}, 32'h0000_BEEF);
    wr(3'd2, 32'hFFFF_00F0);
    chk("DIR oe", {16'd0, goe}, 32'h0000_00F0);

    // Rising-edge interrupt latency
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h1);
    gin[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("irq before edge+3", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq at edge+3", {31'd0, irq}, 32'd1);
    rd("IN bit0", 3'd1, 32'h1);
    rd("STAT rise", 3'd5, 32'h1);
    wr(3'd5, 32'h1);
    chk("irq cleared", {31'd0, irq}, 32'd0);

    // Falling-edge polarity on bit 15
    wr(3'd4, 32'h0);
    wr(3'd3, 32'h8000);
    gin[15] = 1'b1;
    repeat (5) @(negedge clk);
    rd("STAT no rise", 3'd5, 32'h0);
    gin[15] = 1'b0;
    repeat (5) @(negedge clk);
    rd("STAT fall", 3'd5, 32'h8000);
    chk("irq fall", {31'd0, irq}, 32'd1);
    wr(3'd5, 32'hFFFF);

    // Set wins over same-cycle clear
    wr(3'd3, 32'h1);
    wr(3'd4, 32'h1);
    gin[0] = 1'b0;
    repeat (5) @(negedge clk);
    wr(3'd5, 32'h1);
    gin[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(3'd5, 32'h1);
    rd("STAT set wins", 3'd5, 32'h1);

    // Unmapped addresses
    wr(3'd6, 32'hFFFF_FFFF);
    rd("adr6", 3'd6, 32'd0);
    rd("adr7", 3'd7, 32'd0);
    chk("irq before reset", {31'd0, irq}, 32'd1);

    // Asynchronous reset during an acked access
    adr = 3'd0; we = 1'b1; sel = 4'hF; dat = 32'h0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    #1;
    chk("ack pre-reset", {31'd0, ack}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("reset ack", {31'd0, ack}, 32'd0);
    chk("reset irq async", {31'd0, irq}, 32'd0);
    chk("reset gpio", {16'd0, gout}, {16'd0, ROUT});
    chk("reset oe", {16'd0, goe}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cyc = ($urandom_range(0, 3) != 0);
      stb = ($urandom_range(0, 3) != 0);
      we  = $urandom_range(0, 1);
      adr = 3'($urandom_range(0, 7));
      sel = 4'($urandom);
      dat = $urandom;
      if ($urandom_range(0, 3) == 0) gin[$urandom_range(0, W-1)] ^= 1'b1;
      @(negedge clk);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (4) @(negedge clk);
    chk("scoreboard drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
